// File: rtl/bios_program_loader.sv
// Boot-time copier: pulls a block of words from the disk controller into instruction memory
// starting at address 0, then optionally pulses FLAG_biosim to hand fetch over to instruction memory.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | disk read request outstanding for word idx
//   WRITE | writing the captured word to IM[idx]
//   DONE  | one-cycle completion (done, optional FLAG_biosim)
module bios_program_loader #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DISK_ADDR_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       auto_switch,
    input  logic [DISK_ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH:0]        word_count,
    output logic                       disk_req,
    output logic [DISK_ADDR_WIDTH-1:0] disk_addr,
    input  logic                       disk_ack,
    input  logic [31:0]                disk_data,
    output logic                       im_we,
    output logic [ADDR_WIDTH-1:0]      im_addr,
    output logic [31:0]                im_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       FLAG_biosim
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                     state;
    logic [ADDR_WIDTH:0]        idx;
    logic [ADDR_WIDTH:0]        count_q;
    logic [DISK_ADDR_WIDTH-1:0] src_q;
    logic                       auto_q;
    logic [ADDR_WIDTH:0]        clamped_count;
    logic [ADDR_WIDTH:0]        idx_next;

    // The clamp guarantees idx never wraps and overwrites low memory a second time.
    always_comb begin
        clamped_count = word_count;
        if (word_count > MAX_COUNT) begin
            clamped_count = MAX_COUNT;
        end
    end

    assign idx_next = idx + (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            count_q     <= '0;
            src_q       <= '0;
            auto_q      <= 1'b0;
            disk_req    <= 1'b0;
            disk_addr   <= '0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            FLAG_biosim <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_base;
                        count_q <= clamped_count;
                        auto_q  <= auto_switch;
                        idx     <= '0;
                        busy    <= 1'b1;
                        if (clamped_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            disk_req  <= 1'b1;
                            disk_addr <= src_base;
                        end
                    end
                end
                REQ: begin
                    if (disk_ack) begin
                        state    <= WRITE;
                        disk_req <= 1'b0;
                        im_we    <= 1'b1;
                        im_addr  <= idx[ADDR_WIDTH-1:0];
                        im_wdata <= disk_data;
                    end
                end
                WRITE: begin
                    im_we <= 1'b0;
                    if (idx_next == count_q) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        FLAG_biosim <= auto_q;
                    end else begin
                        state     <= REQ;
                        idx       <= idx_next;
                        disk_req  <= 1'b1;
                        disk_addr <= src_q + DISK_ADDR_WIDTH'(idx_next);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    FLAG_biosim <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_program_loader.sv
// Randomized scoreboard bench for bios_program_loader: a disk model answers requests,
// a reference model predicts writes, disk addresses and completion pulses.
module tb_bios_program_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        auto_switch;
    logic [15:0] src_base;
    logic [10:0] word_count;
    logic        disk_req;
    logic [15:0] disk_addr;
    logic        disk_ack;
    logic [31:0] disk_data;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        FLAG_biosim;

    bios_program_loader #(.ADDR_WIDTH(10), .DISK_ADDR_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .start(start), .auto_switch(auto_switch),
        .src_base(src_base), .word_count(word_count),
        .disk_req(disk_req), .disk_addr(disk_addr), .disk_ack(disk_ack), .disk_data(disk_data),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .FLAG_biosim(FLAG_biosim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_edge = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int disk_wait = 0;
    bit stray_en = 0;
    bit mon_en = 0;
    int reqc = 0;
    bit req_prev = 0;

    int unsigned exp_waddr[$];
    logic [31:0] exp_wdata[$];
    logic [15:0] exp_daddr[$];
    bit          exp_flag[$];
    int          exp_lat[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    always @(posedge clock) cyc++;

    // Disk controller: acks after disk_wait extra cycles, junk data otherwise.
    always @(negedge clock) begin
        if (disk_req) begin
            reqc++;
            if (reqc > disk_wait) begin
                disk_ack  = 1'b1;
                disk_data = {16'h0000, disk_addr} ^ 32'hA5A5_0000;
            end else begin
                disk_ack  = 1'b0;
                disk_data = $urandom;
            end
        end else begin
            reqc      = 0;
            disk_ack  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            disk_data = $urandom;
        end
    end

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (mon_en) begin
            if (disk_req && !req_prev) begin
                if (exp_daddr.size() == 0) unexpected("unexpected_disk_req");
                else chk("disk_addr", disk_addr, exp_daddr.pop_front());
            end
            if (im_we) begin
                wr_cnt++;
                if (exp_waddr.size() == 0) unexpected("unexpected_write");
                else begin
                    chk("im_addr", im_addr, exp_waddr.pop_front());
                    chk("im_wdata", im_wdata, exp_wdata.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_flag.size() == 0) unexpected("unexpected_done");
                else begin
                    int lat;
                    lat = exp_lat.pop_front();
                    chk("flag_at_done", FLAG_biosim, exp_flag.pop_front());
                    chk("busy_at_done", busy, 1);
                    if (lat >= 0) chk("done_latency", cyc - start_edge, lat);
                end
            end else if (FLAG_biosim) begin
                unexpected("flag_without_done");
            end
        end
        req_prev = disk_req;
    end

    task automatic run_copy(input logic [15:0] src, input int cnt, input bit aut,
                            input int wt, input bit stray, input bit poke);
        int n;
        int budget;
        int target;
        int wr0;
        n = (cnt > 1024) ? 1024 : cnt;
        disk_wait = wt;
        stray_en = stray;
        for (int i = 0; i < n; i++) begin
            exp_waddr.push_back(i);
            exp_daddr.push_back(16'(int'(src) + i));
            exp_wdata.push_back({16'h0000, 16'(int'(src) + i)} ^ 32'hA5A5_0000);
        end
        exp_flag.push_back(aut && (n > 0));
        exp_lat.push_back((n == 0) ? -1 : n * (wt + 2));
        target = done_cnt + 1;
        wr0 = wr_cnt;
        @(negedge clock);
        start = 1'b1; src_base = src; word_count = 11'(cnt); auto_switch = aut;
        start_edge = cyc + 1;
        @(negedge clock);
        start = 1'b0; src_base = 16'($urandom); word_count = 11'($urandom); auto_switch = 1'($urandom);
        if (poke) begin
            repeat (2) @(negedge clock);
            start = 1'b1; word_count = 11'($urandom_range(1, 50));
            @(negedge clock);
            start = 1'b0;
        end
        budget = n * (wt + 2) + 20;
        while (done_cnt < target && budget > 0) begin
            @(negedge clock); #1;
            budget--;
        end
        if (done_cnt < target) unexpected("done_timeout");
        @(negedge clock); #1;
        chk("busy_after_done", busy, 0);
        chk("writes_left", exp_waddr.size(), 0);
        chk("disk_reqs_left", exp_daddr.size(), 0);
        chk("write_count", wr_cnt - wr0, n);
    endtask

    initial begin
        int budget;
        reset = 1'b1; start = 1'b0; auto_switch = 1'b0; src_base = '0; word_count = '0;
        repeat (3) @(negedge clock);
        chk("rst_disk_req", disk_req, 0);
        chk("rst_disk_addr", disk_addr, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flag", FLAG_biosim, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        run_copy(16'h0100, 4, 1, 0, 0, 0);
        run_copy(16'h0100, 4, 1, 3, 0, 0);
        run_copy(16'h1234, 0, 1, 0, 0, 0);
        run_copy(16'h0200, 2, 0, 0, 0, 0);
        run_copy(16'hFFFE, 3, 1, 1, 0, 0);
        run_copy(16'($urandom), 2047, 1, 0, 0, 0);
        run_copy(16'h0300, 6, 1, 2, 1, 1);

        stray_en = 1'b1;
        repeat (10) begin
            @(negedge clock); #1;
            chk("idle_busy_stray_ack", busy, 0);
        end
        stray_en = 1'b0;

        for (int k = 0; k < 8; k++) begin
            int c;
            c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            run_copy(16'($urandom), c, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 0);
        end

        // Reset during the WRITE of word 2 of 4
        disk_wait = 0;
        for (int i = 0; i < 2; i++) begin
            exp_waddr.push_back(i);
            exp_daddr.push_back(16'(16'h0400 + i));
            exp_wdata.push_back({16'h0000, 16'(16'h0400 + i)} ^ 32'hA5A5_0000);
        end
        @(negedge clock);
        start = 1'b1; src_base = 16'h0400; word_count = 11'd4; auto_switch = 1'b1;
        @(negedge clock);
        start = 1'b0;
        budget = 20;
        while (!(im_we && im_addr == 10'd1) && budget > 0) begin
            @(negedge clock); #1;
            budget--;
        end
        if (budget == 0) unexpected("reset_test_timeout");
        reset = 1'b1;
        @(negedge clock); #1;
        chk("midrst_disk_req", disk_req, 0);
        chk("midrst_disk_addr", disk_addr, 0);
        chk("midrst_im_we", im_we, 0);
        chk("midrst_im_addr", im_addr, 0);
        chk("midrst_im_wdata", im_wdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_flag", FLAG_biosim, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        chk("midrst_writes_left", exp_waddr.size(), 0);
        chk("midrst_busy_after", busy, 0);

        run_copy(16'h0010, 3, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
